uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 47 ++++
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// data width and the default bit period.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEFAULT_BIT_CYCLES = 4166;  // 40 MHz / 9600 baud

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; a push into a full
// FIFO is accepted only when a pop happens on the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the empty flag keeps stale entries unread.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output buffer. Define UART_RX_FIFO_EN
// for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   rx_i,
  output logic [UART_DATA_W-1:0] rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  input  logic                   clear_err_i,
  output logic                   busy_o
);

  localparam int CNT_W = cnt_width(BIT_CYCLES);
  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_W - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [1:0]             sync_q;
  logic [1:0]             sync_vld_q;
  logic                   line_prev_q;
  logic                   line;
  logic                   fall;
  logic                   push;
  logic                   pop;
  logic                   buf_full;
  logic                   frame_err_d;
  logic                   frame_err_q;
  logic                   overrun_q;

  assign line = sync_q[1];
  // line_prev_q is only set once the chain holds real line samples, so a line
  // that is already low when reset releases never looks like a falling edge.
  assign fall = line_prev_q && !line;

  // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q      <= 2'b11;
      sync_vld_q  <= 2'b00;
      line_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
      line_prev_q <= line && sync_vld_q[1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: defaults first in combinational blocks so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = line ? ST_IDLE : ST_DATA;  // high at mid-start: glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[UART_DATA_W-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (line) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (line) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = rx_valid_o && rx_ready_i;

`ifdef UART_RX_FIFO_EN
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_data;

  uart_sync_fifo #(
    .WIDTH(UART_DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (push),
    .push_data(shift_q),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (buf_full),
    .empty    (fifo_empty)
  );

  assign rx_valid_o = !fifo_empty;
  assign rx_data_o  = fifo_empty ? '0 : fifo_data;
`else
  logic [UART_DATA_W-1:0] hold_q;
  logic                   hold_vld_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (push && (!hold_vld_q || pop)) begin
      hold_q     <= shift_q;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end

  assign buf_full   = hold_vld_q;
  assign rx_valid_o = hold_vld_q;
  assign rx_data_o  = hold_q;
`endif

  // A fresh drop wins over a clear arriving on the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overrun_q <= 1'b0;
    end else if (push && buf_full && !pop) begin
      overrun_q <= 1'b1;
    end else if (clear_err_i) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame-level model queues expected bytes and
// a negedge monitor pops and compares whenever a byte is handed over.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int N     = 16;
  localparam int HALF  = N / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  // Falling edge crosses two synchronizer flops plus the edge register, then
  // half a bit to mid-start and nine whole bits to mid-stop.
  localparam int LAT = 3 + HALF + 9 * N;

  logic       wb_clk_i    = 1'b0;
  logic       wb_rst_i    = 1'b1;
  logic       rx_i        = 1'b1;
  logic       rx_ready_i  = 1'b0;
  logic       clear_err_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx #(.BIT_CYCLES(N), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .clear_err_i(clear_err_i),
    .busy_o     (busy_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  int         n_checks    = 0;
  int         n_errors    = 0;
  int         cyc         = 0;
  int         ready_mode  = 1;   // 0: hold low, 1: high, 2: random
  int         fe_cnt      = 0;
  int         last_rise   = 0;
  bit         hold_mode   = 1'b0;
  bit         exp_overrun = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // Frame-level model: in hold mode nothing drains, so occupancy is the queue size.
  function automatic void model_push(input logic [7:0] d);
    if (hold_mode && exp_q.size() >= CAP) exp_overrun = 1'b1;
    else exp_q.push_back(d);
  endfunction

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int stop_bits,
                            output int start_cyc);
    tick(1);
    rx_i      = 1'b0;
    start_cyc = cyc;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx_i = data[i];
      tick(N);
    end
    if (stop_ok) model_push(data);
    rx_i = stop_ok;
    tick(N * stop_bits);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      tick(1);
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k = 0;
    while (busy_o && k < limit) begin
      tick(1);
      k++;
    end
    check(name, busy_o, 1'b0);
  endtask

  // Consumer ready driver, updated just after each rising edge.
  initial forever begin
    @(posedge wb_clk_i);
    #1;
    case (ready_mode)
      0:       rx_ready_i = 1'b0;
      1:       rx_ready_i = 1'b1;
      default: rx_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  logic       valid_d = 1'b0;
  logic       pop_d   = 1'b0;
  logic       fe_d    = 1'b0;
  logic [7:0] data_d  = '0;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      valid_d = 1'b0;
      pop_d   = 1'b0;
      fe_d    = 1'b0;
    end else begin
      if (rx_valid_o && valid_d && !pop_d) check("hold_stable", rx_data_o, data_d);
      if (rx_valid_o && !valid_d) last_rise = cyc;
      if (frame_err_o) begin
        fe_cnt++;
        if (fe_d) begin
          n_checks++;
          n_errors++;
          $display("FAIL frame_err_width: actual=pulse longer than 1 cycle expected=1 cycle");
        end
      end
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: actual=0x%0h expected=no byte", rx_data_o);
        end else begin
          check("rx_data", rx_data_o, exp_q.pop_front());
        end
      end
      valid_d = rx_valid_o;
      pop_d   = rx_valid_o && rx_ready_i;
      fe_d    = frame_err_o;
      data_d  = rx_data_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [7:0] b;

    // Reset with the line already low: no frame until a real 1->0 edge.
    ready_mode = 1;
    rx_i       = 1'b0;
    wb_rst_i   = 1'b1;
    tick(3);
    check("reset_outputs", {rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o}, 0);
    wb_rst_i = 1'b0;
    tick(2 * N);
    check("low_after_reset_busy", busy_o, 1'b0);
    rx_i = 1'b1;
    tick(N);

    // 0x55 with exact handover latency.
    send_frame(8'h55, 1'b1, 1, s);
    wait_drain("drain_0x55", 4 * N);
    check("latency_0x55", last_rise - s, LAT);
    check("no_frame_err_0x55", fe_cnt, 0);

    // Four-cycle glitch is rejected.
    tick(N);
    tick(1);
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    check("glitch_busy_seen", busy_o, 1'b1);
    wait_idle("glitch_busy_clear", 8);
    tick(2 * N);
    check("glitch_no_byte", rx_valid_o, 1'b0);

    // Bad stop bit held for three bit-times, then a good frame.
    send_frame(8'hA3, 1'b0, 3, s);
    check("break_busy", busy_o, 1'b1);
    check("break_frame_err_count", fe_cnt, 1);
    check("break_no_byte", rx_valid_o, 1'b0);
    rx_i = 1'b1;
    wait_idle("break_exit", 8);
    tick(N);
    send_frame(8'h0A, 1'b1, 1, s);
    wait_drain("drain_0x0A", 4 * N);

    // Overflow with the consumer stalled.
    ready_mode = 0;
    tick(2);
    hold_mode   = 1'b1;
    exp_overrun = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1, s);
    tick(N);
    check("overrun_set", overrun_o, exp_overrun);
    check("valid_while_stalled", rx_valid_o, 1'b1);
    hold_mode  = 1'b0;
    ready_mode = 1;
    wait_drain("drain_overflow", 4 * DEPTH + 10);
    tick(2);
    check("overrun_sticky", overrun_o, 1'b1);
    check("empty_after_drain", rx_valid_o, 1'b0);
    clear_err_i = 1'b1;
    tick(1);
    clear_err_i = 1'b0;
    check("overrun_cleared", overrun_o, 1'b0);

    // Reset during data bit 4 of 0x7E, then the same byte intact.
    b = 8'h7E;
    tick(N);
    rx_i = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      tick(N);
    end
    rx_i = b[4];
    tick(HALF);
    wb_rst_i = 1'b1;
    tick(1);
    check("midframe_reset_outputs", {rx_data_o, rx_valid_o, frame_err_o, overrun_o, busy_o}, 0);
    rx_i     = 1'b1;
    wb_rst_i = 1'b0;
    tick(3 * N);
    check("midframe_no_byte", rx_valid_o, 1'b0);
    check("midframe_no_err", fe_cnt, 1);
    send_frame(8'h7E, 1'b1, 1, s);
    wait_drain("drain_0x7E", 4 * N);

    // Random bytes, random gaps, random consumer stalls.
    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1, s);
      tick($urandom_range(0, N));
    end
    wait_drain("drain_random", 8 * N);
    check("total_frame_errs", fe_cnt, 1);
    check("final_overrun", overrun_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
